// File: rtl/wb_ctrl_pipe.sv
// Writeback-stage controller: M->W pipeline register, register-file write decode
// with load extension, and a short history of retired writes for decode forwarding.
module wb_ctrl_pipe #(
  parameter int DATA_W     = 32,
  parameter int HIST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       ins_M,
  input  logic [DATA_W-1:0] alu_res_M,
  input  logic [31:0]       mem_rdata_M,
  input  logic [1:0]        addr_lo_M,
  input  logic [DATA_W-1:0] pc8_M,
  input  logic [DATA_W-1:0] hi_M,
  input  logic [DATA_W-1:0] lo_M,
  input  logic              stall,
  input  logic              flush,
  output logic              valid_W,
  output logic [31:0]       ins_W,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        fwd_rs_addr,
  input  logic [4:0]        fwd_rt_addr,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data
);

  logic [5:0]        op_m;
  logic [5:0]        fn_m;
  logic              dec_wr;
  logic [4:0]        dec_dst;
  logic              is_load;
  logic              is_link;
  logic              is_mfhi;
  logic              is_mflo;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_word;
  logic              next_we;
  logic [DATA_W-1:0] next_data;
  logic              retire;

  logic              hist_v [HIST_DEPTH];
  logic [4:0]        hist_a [HIST_DEPTH];
  logic [DATA_W-1:0] hist_d [HIST_DEPTH];

  logic [DATA_W:0]   rs_res;
  logic [DATA_W:0]   rt_res;

  assign op_m = ins_M[31:26];
  assign fn_m = ins_M[5:0];

  always_comb begin
    dec_wr  = 1'b0;
    dec_dst = ins_M[20:16];
    is_load = 1'b0;
    is_link = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    case (op_m)
      6'h00: begin
        dec_dst = ins_M[15:11];
        case (fn_m)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_wr = 1'b1;
          // funct 0 is sll, but the all-zero word is the canonical nop
          6'h00: dec_wr = |ins_M;
          6'h09: begin dec_wr = 1'b1; is_link = 1'b1; end
          6'h10: begin dec_wr = 1'b1; is_mfhi = 1'b1; end
          6'h12: begin dec_wr = 1'b1; is_mflo = 1'b1; end
          default: dec_wr = 1'b0;
        endcase
      end
      6'h03: begin dec_wr = 1'b1; dec_dst = 5'd31; is_link = 1'b1; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: dec_wr = 1'b1;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin dec_wr = 1'b1; is_load = 1'b1; end
      default: dec_wr = 1'b0;
    endcase
  end

  assign ld_byte = mem_rdata_M[{addr_lo_M, 3'b000} +: 8];
  assign ld_half = addr_lo_M[1] ? mem_rdata_M[31:16] : mem_rdata_M[15:0];

  always_comb begin
    ld_word = mem_rdata_M;
    case (op_m)
      6'h20:   ld_word = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   ld_word = {24'd0, ld_byte};
      6'h21:   ld_word = {{16{ld_half[15]}}, ld_half};
      6'h25:   ld_word = {16'd0, ld_half};
      default: ld_word = mem_rdata_M;
    endcase
  end

  always_comb begin
    next_data = alu_res_M;
    if (is_load)      next_data = DATA_W'(ld_word);
    else if (is_link) next_data = pc8_M;
    else if (is_mfhi) next_data = hi_M;
    else if (is_mflo) next_data = lo_M;
  end

  assign next_we = in_valid & dec_wr & (dec_dst != 5'd0);

  // wb_addr/wb_data read as zero whenever no write is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_W <= 1'b0;
      ins_W   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (flush) begin
      valid_W <= 1'b0;
      ins_W   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (!stall) begin
      valid_W <= in_valid;
      ins_W   <= in_valid ? ins_M : 32'd0;
      wb_we   <= next_we;
      wb_addr <= next_we ? dec_dst : 5'd0;
      wb_data <= next_we ? next_data : '0;
    end
  end

  // W leaves the stage on any edge that is not a pure stall
  assign retire = (flush | ~stall) & wb_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_v[i] <= 1'b0;
        hist_a[i] <= '0;
        hist_d[i] <= '0;
      end
    end else if (retire) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_v[i] <= hist_v[i-1];
        hist_a[i] <= hist_a[i-1];
        hist_d[i] <= hist_d[i-1];
      end
      hist_v[0] <= 1'b1;
      hist_a[0] <= wb_addr;
      hist_d[0] <= wb_data;
    end
  end

  // Scan oldest to newest so the newest match overwrites; W has final say
  always_comb begin
    rs_res = '0;
    rt_res = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (hist_v[i] && hist_a[i] == fwd_rs_addr) rs_res = {1'b1, hist_d[i]};
      if (hist_v[i] && hist_a[i] == fwd_rt_addr) rt_res = {1'b1, hist_d[i]};
    end
    if (wb_we && wb_addr == fwd_rs_addr) rs_res = {1'b1, wb_data};
    if (wb_we && wb_addr == fwd_rt_addr) rt_res = {1'b1, wb_data};
    if (fwd_rs_addr == 5'd0) rs_res = '0;
    if (fwd_rt_addr == 5'd0) rt_res = '0;
  end

  assign fwd_rs_hit  = rs_res[DATA_W];
  assign fwd_rs_data = rs_res[DATA_W-1:0];
  assign fwd_rt_hit  = rt_res[DATA_W];
  assign fwd_rt_data = rt_res[DATA_W-1:0];

endmodule
